// File: rtl/shared_adder_scheduler.sv
// Two-requester add/subtract unit: one 4-bit ripple slice is reused over four cycles
// to build a 16-bit result, with round-robin arbitration between the requesters.
module shared_adder_scheduler #(
  parameter int unsigned RR_INIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [15:0] a0_in,
  input  logic [15:0] b0_in,
  input  logic        sub0,
  input  logic        req1,
  input  logic [15:0] a1_in,
  input  logic [15:0] b1_in,
  input  logic        sub1,
  output logic        ack0,
  output logic        ack1,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic [15:0] result,
  output logic        cout,
  output logic        ovf
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      r_state, w_state_d;
  logic [1:0]  r_slice;
  logic        r_ptr, r_gnt, r_sub, r_carry;
  logic [15:0] r_a, r_b, r_acc;
  logic        r_ack0, r_ack1, r_done, r_done_id, r_cout, r_ovf;
  logic [15:0] r_result;

  logic        w_gnt, w_capture, w_cin;
  logic [3:0]  w_a_nib, w_b_nib, w_sum;
  logic [4:0]  w_c;

  // With both requests pending the pointer decides; otherwise the lone requester wins.
  assign w_gnt     = (req0 & req1) ? r_ptr : req1;
  assign w_capture = (r_state == StIdle) & (req0 | req1);

  assign w_a_nib = r_a[{r_slice, 2'b00} +: 4];
  assign w_b_nib = r_b[{r_slice, 2'b00} +: 4];
  assign w_cin   = (r_slice == 2'd0) ? r_sub : r_carry;

  always_comb begin
    w_c    = '0;
    w_sum  = '0;
    w_c[0] = w_cin;
    for (int i = 0; i < 4; i++) begin
      w_sum[i]  = w_a_nib[i] ^ w_b_nib[i] ^ w_c[i];
      w_c[i+1]  = (w_a_nib[i] & w_b_nib[i]) | (w_c[i] & (w_a_nib[i] ^ w_b_nib[i]));
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (req0 | req1) w_state_d = StRun;
      StRun:   if (r_slice == 2'd3) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_slice <= 2'd0;
    end else begin
      r_state <= w_state_d;
      if (w_capture) begin
        r_slice <= 2'd0;
      end else if (r_state == StRun) begin
        r_slice <= r_slice + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= 1'(RR_INIT);
      r_gnt     <= 1'b0;
      r_sub     <= 1'b0;
      r_carry   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_result  <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_done <= 1'b0;
      if (w_capture) begin
        r_gnt  <= w_gnt;
        r_ptr  <= ~w_gnt;
        r_ack0 <= ~w_gnt;
        r_ack1 <= w_gnt;
        r_a    <= w_gnt ? a1_in : a0_in;
        r_sub  <= w_gnt ? sub1 : sub0;
        // B is stored already conditioned (inverted for subtraction).
        r_b    <= w_gnt ? (sub1 ? ~b1_in : b1_in) : (sub0 ? ~b0_in : b0_in);
      end
      if (r_state == StRun) begin
        r_acc[{r_slice, 2'b00} +: 4] <= w_sum;
        r_carry <= w_c[4];
        if (r_slice == 2'd3) begin
          r_result  <= {w_sum, r_acc[11:0]};
          r_cout    <= w_c[4];
          r_ovf     <= (r_a[15] == r_b[15]) & (w_sum[3] != r_a[15]);
          r_done_id <= r_gnt;
          r_done    <= 1'b1;
        end
      end
    end
  end

  assign ack0    = r_ack0;
  assign ack1    = r_ack1;
  assign busy    = (r_state != StIdle);
  assign done    = r_done;
  assign done_id = r_done_id;
  assign result  = r_result;
  assign cout    = r_cout;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_shared_adder_scheduler.sv
// Randomised and directed bench for shared_adder_scheduler against an arithmetic model.
module tb_shared_adder_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, sub0 = 1'b0, req1 = 1'b0, sub1 = 1'b0;
  logic [15:0] a0_in = '0, b0_in = '0, a1_in = '0, b1_in = '0;
  logic        ack0, ack1, busy, done, done_id, cout, ovf;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  shared_adder_scheduler #(.RR_INIT(0)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0_in(a0_in), .b0_in(b0_in), .sub0(sub0),
    .req1(req1), .a1_in(a1_in), .b1_in(b1_in), .sub1(sub1),
    .ack0(ack0), .ack1(ack1), .busy(busy), .done(done), .done_id(done_id),
    .result(result), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns {ovf, cout, result} from signed/unsigned integer arithmetic.
  function automatic logic [17:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic s);
    int sa, sb, sr;
    logic [15:0] r;
    logic c, v;
    sa = $signed(a);
    sb = $signed(b);
    sr = s ? (sa - sb) : (sa + sb);
    v  = (sr > 32767) || (sr < -32768);
    if (s) begin
      r = a - b;
      c = (a >= b);
    end else begin
      r = a + b;
      c = ((int'(a) + int'(b)) > 65535);
    end
    return {v, c, r};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({ack0, ack1, busy, done, done_id, cout, ovf} !== 7'b0 || result !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ack0=%b ack1=%b busy=%b done=%b id=%b res=%h c=%b v=%b, want all 0",
               ack0, ack1, busy, done, done_id, result, cout, ovf);
    end
    rst = 1'b0;
  endtask

  // Issue one request, check grant, latency, outputs, and hold after done.
  task automatic run_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input bit perturb, input string name);
    logic [17:0] exp;
    bit got;
    int lat;
    got = 0;
    exp = ref_model(a, b, s);
    if (id) begin req1 = 1'b1; a1_in = a; b1_in = b; sub1 = s; end
    else    begin req0 = 1'b1; a0_in = a; b0_in = b; sub0 = s; end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack0 | ack1) begin got = 1; break; end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s ack_timeout: got no ack, want ack%0d", name, id);
      return;
    end
    checks++;
    if ({ack1, ack0, done} !== {id, ~id, 1'b0}) begin
      errors++;
      $display("FAIL %s grant: got ack1=%b ack0=%b done=%b, want ack%0d only", name, ack1, ack0,
               done, id);
    end
    lat = 0;
    got = 0;
    for (int i = 1; i <= 10; i++) begin
      if (perturb) begin
        a0_in = 16'($urandom); b0_in = 16'($urandom); sub0 = 1'($urandom);
        a1_in = 16'($urandom); b1_in = 16'($urandom); sub1 = 1'($urandom);
      end
      tick();
      if (done) begin lat = i; got = 1; break; end
    end
    checks++;
    if (!got || lat != 4) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, want 4", name, lat);
    end
    checks++;
    if ({ovf, cout, result} !== exp || done_id !== id) begin
      errors++;
      $display("FAIL %s result: got res=%h c=%b v=%b id=%b, want res=%h c=%b v=%b id=%b", name,
               result, cout, ovf, done_id, exp[15:0], exp[16], exp[17], id);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || {ovf, cout, result} !== exp || done_id !== id) begin
      errors++;
      $display("FAIL %s hold: got done=%b busy=%b res=%h id=%b, want done=0 busy=0 res=%h id=%b",
               name, done, busy, result, done_id, exp[15:0], id);
    end
  endtask

  task automatic test_directed();
    run_op(1'b0, 16'h1234, 16'h0FFF, 1'b0, 0, "add_basic");
    run_op(1'b1, 16'h0005, 16'h0007, 1'b1, 0, "sub_borrow");
    run_op(1'b1, 16'h0007, 16'h0005, 1'b1, 0, "sub_noborrow");
    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 0, "add_ovf");
    run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 0, "add_carry");
    run_op(1'b0, 16'h8000, 16'h0001, 1'b1, 0, "sub_ovf");
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      run_op(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), bit'(n % 3 == 0),
             "random");
    end
  endtask

  task automatic test_operand_change();
    run_op(1'b0, 16'hA5A5, 16'h1357, 1'b1, 1, "perturb0");
    run_op(1'b1, 16'h4000, 16'h4000, 1'b0, 1, "perturb1");
  endtask

  task automatic test_arbitration();
    logic [17:0] exp0, exp1;
    logic exp_gnt, last_gnt;
    int grants, dones, last_done;
    rst = 1'b1;
    tick();
    req0 = 1'b1; a0_in = 16'h1111; b0_in = 16'h0101; sub0 = 1'b0;
    req1 = 1'b1; a1_in = 16'h2222; b1_in = 16'h0001; sub1 = 1'b1;
    exp0 = ref_model(16'h1111, 16'h0101, 1'b0);
    exp1 = ref_model(16'h2222, 16'h0001, 1'b1);
    rst = 1'b0;
    exp_gnt = 1'b0;
    last_gnt = 1'b0;
    grants = 0;
    dones = 0;
    last_done = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      if (ack0 | ack1) begin
        checks++;
        if ({ack1, ack0} !== {exp_gnt, ~exp_gnt} || done !== 1'b0) begin
          errors++;
          $display("FAIL arb_grant: got ack1=%b ack0=%b done=%b, want ack%0d", ack1, ack0, done,
                   exp_gnt);
        end
        last_gnt = exp_gnt;
        exp_gnt = ~exp_gnt;
        grants++;
      end
      if (done) begin
        checks++;
        if (done_id !== last_gnt || {ovf, cout, result} !== (last_gnt ? exp1 : exp0) ||
            (last_done >= 0 && cyc - last_done != 6)) begin
          errors++;
          $display("FAIL arb_done: got id=%b res=%h gap=%0d, want id=%b res=%h gap=6", done_id,
                   result, cyc - last_done, last_gnt, last_gnt ? exp1[15:0] : exp0[15:0]);
        end
        last_done = cyc;
        dones++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    checks++;
    if (dones < 5 || grants < dones || grants > dones + 1) begin
      errors++;
      $display("FAIL arb_count: got grants=%0d dones=%0d, want >=5 dones, one per grant", grants,
               dones);
    end
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_reset_mid();
    bit got;
    int spurious;
    got = 0;
    spurious = 0;
    req0 = 1'b1; a0_in = 16'h0F0F; b0_in = 16'h00F1; sub0 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack0) begin got = 1; break; end
    end
    req0 = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rstmid_ack: got no ack0, want ack0");
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({ack0, ack1, busy, done, done_id, cout, ovf} !== 7'b0 || result !== 16'h0) begin
      errors++;
      $display("FAIL rstmid_outputs: got busy=%b done=%b id=%b res=%h c=%b v=%b, want all 0",
               busy, done, done_id, result, cout, ovf);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done | ack0 | ack1 | busy) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL rstmid_abort: got %0d active cycles after reset, want 0", spurious);
    end
    run_op(1'b0, 16'h0F0F, 16'h00F1, 1'b0, 0, "after_rst");
  endtask

  task automatic test_back_to_back();
    req0 = 1'b1; a0_in = 16'h0100; b0_in = 16'h0001; sub0 = 1'b1;
    run_op(1'b0, 16'h0100, 16'h0001, 1'b1, 0, "b2b_first");
    run_op(1'b0, 16'h8001, 16'h8001, 1'b0, 0, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_operand_change();
    test_arbitration();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_adder_scheduler.md
SHARED_ADDER_SCHEDULER -- requirements
Module: shared_adder_scheduler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset named rst.
REQ-002 Parameter: RR_INIT, default 0, index of the requester holding priority after reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req0  input  1  requester 0 operation request.
REQ-006 a0_in  input  16  requester 0 operand A.
REQ-007 b0_in  input  16  requester 0 operand B.
REQ-008 sub0  input  1  requester 0 op select: 0 = A+B, 1 = A-B.
REQ-009 req1, a1_in, b1_in, sub1  input  1/16/16/1  requester 1 equivalents of REQ-005..008.
REQ-010 ack0, ack1  output  1 each  one-cycle pulse: operands of that requester captured.
REQ-011 busy  output  1  high in RUN and DONE states.
REQ-012 done  output  1  one-cycle pulse: result, cout, ovf and done_id valid.
REQ-013 done_id  output  1  requester served by the current done.
REQ-014 result  output  16  sum/difference.
REQ-015 cout  output  1  carry out of bit 15.
REQ-016 ovf  output  1  two's-complement signed overflow.

Function
REQ-017 A single 4-bit full-adder slice (sum/carry per bit, rippled) SHALL be time-shared to produce the 16-bit result over 4 cycles, nibble 0 first.
REQ-018 States SHALL be IDLE, RUN (2-bit slice counter 0..3), and DONE.
REQ-019 IDLE with any reqN high at a clock edge: capture that requester's A, B, and sub; enter RUN with slice 0; assert ackN in the following cycle only.
REQ-020 Arbitration: a single request is granted regardless of the pointer. With both requests high, grant the pointer's requester. After every grant, the pointer moves to the non-granted requester.
REQ-021 Per RUN cycle s, the slice SHALL compute A[4s+3:4s] + B'[4s+3:4s] + c.
  - B' = ~B if sub, else B.
  - c = sub for s=0; otherwise the registered carry from slice s-1.
  - The sum is written to the internal nibble s, and the carry is registered.
REQ-022 After slice 3, the FSM SHALL enter DONE for exactly one cycle, then IDLE.
REQ-023 In the DONE cycle, the following SHALL hold:
  - done = 1.
  - done_id = granted requester.
  - result = the 16 computed bits.
  - cout = slice-3 carry.
  - ovf = (A[15] == B'[15]) & (result[15] != A[15]).
REQ-024 result, cout, ovf and done_id SHALL hold their values until the next done.
REQ-025 Latency: ack in cycle k, done in cycle k+4; earliest next capture at the edge ending cycle k+5 (IDLE).
REQ-026 For subtraction, cout = 1 SHALL mean no borrow.
REQ-027 Changes to operands or sub after capture SHALL NOT affect the in-flight result.
REQ-028 Requests in RUN/DONE SHALL be ignored (not queued); requesters hold reqN until ackN.
REQ-029 A reqN still high when the FSM returns to IDLE SHALL be treated as a new request.
REQ-030 ack0 and ack1 SHALL never be high in the same cycle, and done SHALL never coincide with either ack.

Reset
REQ-031 While rst is high at a clock edge, the block SHALL reset as follows:
  - State → IDLE, slice counter → 0, pointer → RR_INIT.
  - Outputs ack0, ack1, busy, done, done_id, result, cout, ovf all → 0.
REQ-032 Reset during RUN or DONE SHALL abort the operation with no done pulse; requests SHALL be accepted at the first edge after rst deasserts.

Verification
REQ-033 req0, 0x1234 + 0x0FFF, sub0=0 -> ack0; done 4 cycles later; result 0x2233, cout 0, ovf 0, done_id 0.
REQ-034 req1, 0x0005 - 0x0007 -> result 0xFFFE, cout 0, ovf 0, done_id 1. Second case: 0x0007 - 0x0005 -> 0x0002, cout 1.
REQ-035 0x7FFF + 0x0001 -> 0x8000, ovf 1, cout 0. 0xFFFF + 0x0001 -> 0x0000, cout 1, ovf 0. 0x8000 - 0x0001 -> 0x7FFF, ovf 1.
REQ-036 After reset with RR_INIT=0, req0 and req1 held high continuously -> grants alternate 0,1,0,1; exactly one done per grant, spaced 6 cycles apart.
REQ-037 Assert rst during RUN slice 2 -> no done; all outputs 0 next cycle; a req0 issued after rst deasserts completes normally.
REQ-038 After ack0, change a0_in/b0_in/sub0 every cycle -> result matches the operands captured at ack.
